// File: rtl/rtc_ascii_counter.sv
// Time-of-day stopwatch (HH:MM:SS:CC, 24 h) kept as cascaded BCD counters,
// presented as ASCII digit bytes for the LCD "Time" line.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   run        1 = prescaler and time advance, 0 = hold
//   clr        synchronous clear of time and prescaler
//   load_req   level request to load load_hh/load_mm/load_ss (BCD)
//   load_ack   one-cycle pulse, load accepted
//   load_err   one-cycle pulse, load rejected (bad BCD or out of range)
//   tick       one-cycle pulse on every centisecond increment
//   day_wrap   one-cycle pulse on 23:59:59:99 -> 00:00:00:00
//   cnt_*, sec_*, min_*, hour_*  ASCII digits {4'h3, bcd}, combinational
module rtc_ascii_counter #(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned DIV_W    = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       load_req,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_ack,
  output logic       load_err,
  output logic       tick,
  output logic       day_wrap,
  output logic [7:0] cnt_1,
  output logic [7:0] cnt_10,
  output logic [7:0] sec_1,
  output logic [7:0] sec_10,
  output logic [7:0] min_1,
  output logic [7:0] min_10,
  output logic [7:0] hour_1,
  output logic [7:0] hour_10
);

  localparam int unsigned FIELD_W = 8;
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [FIELD_W-1:0] CC_MAX = 8'h99;
  localparam logic [FIELD_W-1:0] SS_MAX = 8'h59;
  localparam logic [FIELD_W-1:0] MM_MAX = 8'h59;
  localparam logic [FIELD_W-1:0] HH_MAX = 8'h23;

  // Two-digit BCD increment that wraps to 00 when the field is at its maximum.
  function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    logic [FIELD_W-1:0] r;
    if (v == max)           r = '0;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Both nibbles decimal and the value no larger than the field maximum.
  function automatic logic bcd_ok(input logic [FIELD_W-1:0] v,
                                  input logic [FIELD_W-1:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  logic [DIV_W-1:0]   presc_q, presc_nxt;
  logic [FIELD_W-1:0] cc_q, ss_q, mm_q, hh_q;
  logic [FIELD_W-1:0] cc_nxt, ss_nxt, mm_nxt, hh_nxt;
  logic               ack_nxt, err_nxt, tick_nxt, wrap_nxt;
  logic               load_ok_c, tick_due_c;

  assign load_ok_c  = bcd_ok(load_hh, HH_MAX) && bcd_ok(load_mm, MM_MAX) &&
                      bcd_ok(load_ss, SS_MAX);
  assign tick_due_c = run && (presc_q == PRESC_LAST);

  // Next-state: clr > valid load > prescaler/cascade.
  always_comb begin
    presc_nxt = presc_q;
    cc_nxt    = cc_q;
    ss_nxt    = ss_q;
    mm_nxt    = mm_q;
    hh_nxt    = hh_q;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    if (clr) begin
      presc_nxt = '0;
      cc_nxt    = '0;
      ss_nxt    = '0;
      mm_nxt    = '0;
      hh_nxt    = '0;
    end else if (load_req && load_ok_c) begin
      presc_nxt = '0;
      cc_nxt    = '0;
      ss_nxt    = load_ss;
      mm_nxt    = load_mm;
      hh_nxt    = load_hh;
      ack_nxt   = 1'b1;
    end else begin
      // A rejected load leaves timekeeping untouched, so no centisecond is lost.
      err_nxt = load_req;
      if (tick_due_c) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
        wrap_nxt  = (cc_q == CC_MAX) && (ss_q == SS_MAX) &&
                    (mm_q == MM_MAX) && (hh_q == HH_MAX);
        cc_nxt    = bcd_inc(cc_q, CC_MAX);
        if (cc_q == CC_MAX) begin
          ss_nxt = bcd_inc(ss_q, SS_MAX);
          if (ss_q == SS_MAX) begin
            mm_nxt = bcd_inc(mm_q, MM_MAX);
            if (mm_q == MM_MAX) hh_nxt = bcd_inc(hh_q, HH_MAX);
          end
        end
      end else if (run) begin
        presc_nxt = presc_q + DIV_W'(1);
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q  <= '0;
      cc_q     <= '0;
      ss_q     <= '0;
      mm_q     <= '0;
      hh_q     <= '0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      presc_q  <= presc_nxt;
      cc_q     <= cc_nxt;
      ss_q     <= ss_nxt;
      mm_q     <= mm_nxt;
      hh_q     <= hh_nxt;
      load_ack <= ack_nxt;
      load_err <= err_nxt;
      tick     <= tick_nxt;
      day_wrap <= wrap_nxt;
    end
  end

  // ASCII digits straight from the BCD registers.
  assign cnt_1   = {4'h3, cc_q[3:0]};
  assign cnt_10  = {4'h3, cc_q[7:4]};
  assign sec_1   = {4'h3, ss_q[3:0]};
  assign sec_10  = {4'h3, ss_q[7:4]};
  assign min_1   = {4'h3, mm_q[3:0]};
  assign min_10  = {4'h3, mm_q[7:4]};
  assign hour_1  = {4'h3, hh_q[3:0]};
  assign hour_10 = {4'h3, hh_q[7:4]};

endmodule
